// File: rtl/cbus_mem_responder.sv
// Memory-side responder for the simplified burst cache bus: serves FIXED/INCR/WRAP
// read and write bursts from a 64-bit word array after a fixed access latency.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN2  = 8'd1;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       oor_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   lat_cnt_reg, lat_cnt_next;
    logic [7:0]      beat_reg, beat_next;
    logic [63:0]     start_addr_reg, start_addr_next;
    logic [63:0]     beat_addr_reg, beat_addr_next;
    logic [2:0]      size_reg, size_next;
    logic [7:0]      len_reg, len_next;
    logic [1:0]      burst_reg, burst_next;
    logic            is_write_reg, is_write_next;

    logic [63:0]     mem [MEM_WORDS];

    logic [63:0]     word_off;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic [63:0]     rd_word;
    logic [63:0]     wr_word;
    logic            mem_we;

    logic [7:0]      next_beat;
    logic [63:0]     beat_ofs;
    logic [63:0]     wrap_mask;
    logic            wrap_ok;
    logic [63:0]     next_addr;

    // Range test and index come only from the latched beat address.
    assign word_off = beat_addr_reg - BASE_ADDR;
    assign in_range = (beat_addr_reg >= BASE_ADDR) && (word_off < MEM_BYTES);
    assign word_idx = word_off[AW+2:3];
    assign rd_word  = mem[word_idx];
    assign mem_we   = (state_reg == BURST) && is_write_reg && creq.valid && in_range;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign wr_word[8*gi +: 8] = creq.strobe[gi] ? creq.data[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Address of beat (beat_reg + 1), computed from the start address.
    always_comb begin
        next_beat = beat_reg + 8'd1;
        beat_ofs  = 64'(next_beat) << size_reg;
        wrap_mask = ((64'(len_reg) + 64'd1) << size_reg) - 64'd1;
        wrap_ok   = (burst_reg == BURST_WRAP) &&
                    ((len_reg == 8'd1) || (len_reg == 8'd3) || (len_reg == 8'd7) || (len_reg == 8'd15));
        next_addr = start_addr_reg + beat_ofs;
        if (burst_reg == BURST_FIXED) begin
            next_addr = start_addr_reg;
        end else if (wrap_ok) begin
            next_addr = (start_addr_reg & ~wrap_mask) | ((start_addr_reg + beat_ofs) & wrap_mask);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= '0;
            beat_reg       <= '0;
            start_addr_reg <= '0;
            beat_addr_reg  <= '0;
            size_reg       <= '0;
            len_reg        <= '0;
            burst_reg      <= '0;
            is_write_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lat_cnt_reg    <= lat_cnt_next;
            beat_reg       <= beat_next;
            start_addr_reg <= start_addr_next;
            beat_addr_reg  <= beat_addr_next;
            size_reg       <= size_next;
            len_reg        <= len_next;
            burst_reg      <= burst_next;
            is_write_reg   <= is_write_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lat_cnt_next    = lat_cnt_reg;
        beat_next       = beat_reg;
        start_addr_next = start_addr_reg;
        beat_addr_next  = beat_addr_reg;
        size_next       = size_reg;
        len_next        = len_reg;
        burst_next      = burst_reg;
        is_write_next   = is_write_reg;
        unique case (state_reg)
            IDLE: begin
                if (creq.valid) begin
                    start_addr_next = creq.addr;
                    beat_addr_next  = creq.addr;
                    size_next       = creq.size;
                    len_next        = creq.len;
                    burst_next      = creq.burst;
                    is_write_next   = creq.is_write;
                    beat_next       = 8'd0;
                    lat_cnt_next    = CW'(LATENCY);
                    state_next      = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_next = IDLE;
                end else if (lat_cnt_reg <= CW'(1)) begin
                    lat_cnt_next = '0;
                    state_next   = BURST;
                end else begin
                    lat_cnt_next = lat_cnt_reg - CW'(1);
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_next = IDLE;
                end else if (beat_reg == len_reg) begin
                    state_next = DONE;
                end else begin
                    beat_next      = next_beat;
                    beat_addr_next = next_addr;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cresp   = '0;
        oor_err = 1'b0;
        if (state_reg == BURST) begin
            cresp.ready = 1'b1;
            cresp.last  = (beat_reg == len_reg);
            oor_err     = !in_range;
            if (!is_write_reg && in_range) begin
                cresp.data = rd_word;
            end
        end
    end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: bus transactions with hand-computed
// expected read data, beat flags and first-beat latency.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic       clk;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       oor_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] wdata [16];
    logic [63:0] rdata [16];
    logic        rlast [16];
    logic        roor  [16];
    int          nbeats;
    int          lat;
    logic        post_zero;

    cbus_mem_responder #(
        .MEM_WORDS(4096),
        .BASE_ADDR(BASE),
        .LATENCY(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .creq(creq),
        .cresp(cresp),
        .oor_err(oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transaction; abort_at >= 0 drops valid before that beat index.
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] strb, input int abort_at);
        int  cyc;
        int  beat;
        bit  fin;
        cyc = 0; beat = 0; fin = 0;
        nbeats = 0; lat = -1; post_zero = 1'b0;
        @(posedge clk); #1;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = addr;
        creq.len      = len;
        creq.size     = size;
        creq.burst    = burst;
        creq.strobe   = strb;
        creq.data     = wdata[0];
        while (!fin) begin
            @(negedge clk);
            if (cyc > 100 || beat >= 16) begin
                check_value("txn_timeout", 64'(cyc), 64'd0);
                creq.valid = 1'b0;
                fin = 1;
            end else if (cresp.ready) begin
                if (lat < 0) lat = cyc;
                rdata[beat] = cresp.data;
                rlast[beat] = cresp.last;
                roor[beat]  = oor_err;
                beat++;
                nbeats = beat;
                if (cresp.last) begin
                    @(posedge clk); #1;
                    creq.valid = 1'b0;
                    @(negedge clk);
                    post_zero = !cresp.ready && !cresp.last && (cresp.data == 64'd0) && !oor_err;
                    fin = 1;
                end else begin
                    @(posedge clk); #1;
                    if (beat < 16) creq.data = wdata[beat];
                    if (beat == abort_at) begin
                        creq.valid = 1'b0;
                        fin = 1;
                        repeat (2) @(posedge clk);
                        #1;
                    end
                end
            end
            cyc++;
        end
        $display("txn wr=%0d addr=%h len=%0d beats=%0d lat=%0d", wr, addr, len, nbeats, lat);
    endtask

    initial begin
        int rc;
        creq   = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_ready", 64'(cresp.ready), 64'd0);
        check_value("reset_last",  64'(cresp.last),  64'd0);
        check_value("reset_data",  cresp.data,       64'd0);
        check_value("reset_oor",   64'(oor_err),     64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single-beat write then read of word 0
        wdata[0] = 64'h1122334455667788;
        run_txn(1'b1, BASE, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("wr0_beats", 64'(nbeats), 64'd1);
        check_value("wr0_data_zero", rdata[0], 64'd0);
        run_txn(1'b0, BASE, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("rd0_latency", 64'(lat), 64'd3);
        check_value("rd0_data", rdata[0], 64'h1122334455667788);
        check_value("rd0_last", 64'(rlast[0]), 64'd1);
        check_value("rd0_post_zero", 64'(post_zero), 64'd1);

        // INCR write burst of 4 then readback
        for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
        run_txn(1'b1, BASE + 64'h20, MLEN4, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("incr_wr_beats", 64'(nbeats), 64'd4);
        run_txn(1'b0, BASE + 64'h20, MLEN4, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("incr_rd_beats", 64'(nbeats), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("incr_rd_data%0d", i), rdata[i], 64'(i + 1));
            check_value($sformatf("incr_rd_last%0d", i), 64'(rlast[i]), (i == 3) ? 64'd1 : 64'd0);
        end

        // WRAP read starting mid-window: C, D, A, B
        wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        wdata[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wdata[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        wdata[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        run_txn(1'b1, BASE + 64'h40, MLEN4, MSIZE8, BURST_INCR, 8'hFF, -1);
        run_txn(1'b0, BASE + 64'h50, MLEN4, MSIZE8, BURST_WRAP, 8'hFF, -1);
        check_value("wrap_b0", rdata[0], 64'hCCCC_CCCC_CCCC_CCCC);
        check_value("wrap_b1", rdata[1], 64'hDDDD_DDDD_DDDD_DDDD);
        check_value("wrap_b2", rdata[2], 64'hAAAA_AAAA_AAAA_AAAA);
        check_value("wrap_b3", rdata[3], 64'hBBBB_BBBB_BBBB_BBBB);
        check_value("wrap_last", 64'(rlast[3]), 64'd1);

        // FIXED read repeats the start word
        run_txn(1'b0, BASE + 64'h48, 8'd2, MSIZE8, BURST_FIXED, 8'hFF, -1);
        for (int i = 0; i < 3; i++)
            check_value($sformatf("fixed_b%0d", i), rdata[i], 64'hBBBB_BBBB_BBBB_BBBB);

        // Strobed single-byte write into lane 2 of word 1
        wdata[0] = 64'd0;
        run_txn(1'b1, BASE + 64'h08, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        wdata[0] = 64'h1111_2222_33CD_4455;
        run_txn(1'b1, BASE + 64'h0A, MLEN1, MSIZE1, BURST_INCR, 8'b0000_0100, -1);
        run_txn(1'b0, BASE + 64'h08, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("strobe_rd", rdata[0], 64'h0000_0000_00CD_0000);

        // Last word of the array is in range
        wdata[0] = 64'h5A5A_5A5A_0123_4567;
        run_txn(1'b1, BASE + 64'h7FF8, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        run_txn(1'b0, BASE + 64'h7FF8, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("top_word_data", rdata[0], 64'h5A5A_5A5A_0123_4567);
        check_value("top_word_oor", 64'(roor[0]), 64'd0);

        // Read crossing from below BASE into word 0
        run_txn(1'b0, BASE - 64'h8, MLEN2, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("oor_rd_beats", 64'(nbeats), 64'd2);
        check_value("oor_rd_data0", rdata[0], 64'd0);
        check_value("oor_rd_flag0", 64'(roor[0]), 64'd1);
        check_value("oor_rd_data1", rdata[1], 64'h1122334455667788);
        check_value("oor_rd_flag1", 64'(roor[1]), 64'd0);
        check_value("oor_rd_last1", 64'(rlast[1]), 64'd1);

        // Write just past the array must be dropped (would alias word 0)
        wdata[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        run_txn(1'b1, BASE + 64'h8000, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("oor_wr_flag", 64'(roor[0]), 64'd1);
        check_value("oor_wr_last", 64'(rlast[0]), 64'd1);
        run_txn(1'b0, BASE, MLEN1, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("oor_wr_unchanged", rdata[0], 64'h1122334455667788);

        // Abort an INCR8 write before beat 2
        for (int i = 0; i < 8; i++) wdata[i] = 64'hEEEE_EEEE_EEEE_EEEE;
        run_txn(1'b1, BASE + 64'h100, MLEN8, MSIZE8, BURST_INCR, 8'hFF, -1);
        for (int i = 0; i < 8; i++) wdata[i] = 64'h100 + 64'(i);
        run_txn(1'b1, BASE + 64'h100, MLEN8, MSIZE8, BURST_INCR, 8'hFF, 2);
        check_value("abort_beats", 64'(nbeats), 64'd2);
        run_txn(1'b0, BASE + 64'h100, MLEN8, MSIZE8, BURST_INCR, 8'hFF, -1);
        for (int i = 0; i < 8; i++)
            check_value($sformatf("abort_rd%0d", i), rdata[i],
                        (i < 2) ? (64'h100 + 64'(i)) : 64'hEEEE_EEEE_EEEE_EEEE);

        // Reset during the first beat of a write burst
        @(posedge clk); #1;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = BASE + 64'h20;
        creq.len      = MLEN4;
        creq.size     = MSIZE8;
        creq.burst    = BURST_INCR;
        creq.strobe   = 8'hFF;
        creq.data     = 64'h9999_9999_9999_9999;
        rc = 0;
        @(negedge clk);
        while (!cresp.ready && rc < 50) begin
            @(negedge clk);
            rc++;
        end
        check_value("rst_reached_burst", 64'(cresp.ready), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_value("rst_ready", 64'(cresp.ready), 64'd0);
        check_value("rst_last",  64'(cresp.last),  64'd0);
        check_value("rst_oor",   64'(oor_err),     64'd0);
        creq.valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        run_txn(1'b0, BASE + 64'h20, MLEN4, MSIZE8, BURST_INCR, 8'hFF, -1);
        check_value("post_rst_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("post_rst_rd%0d", i), rdata[i], 64'(i + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
